// File: rtl/sram_block_reader_if.sv
// Bundle of the command, SRAM-wrapper and output-stream signals of sram_block_reader.
// The master modport is the reader itself; slave is the surrounding system.
interface sram_block_reader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 7,
  parameter int LEN_W  = 8
);
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  num_rows;
  logic              busy;
  logic              done;
  logic              cmd_err;
  logic              sram_mem_en;
  logic              sram_rd_req;
  logic              sram_wr_req;
  logic [ADDR_W-1:0] sram_address;
  logic [DATA_W-1:0] sram_rd_data;
  logic              sram_rd_data_val;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  start, base_addr, num_rows, sram_rd_data, sram_rd_data_val, out_ready,
    output busy, done, cmd_err, sram_mem_en, sram_rd_req, sram_wr_req, sram_address,
           out_data, out_valid
  );

  modport slave (
    output start, base_addr, num_rows, sram_rd_data, sram_rd_data_val, out_ready,
    input  busy, done, cmd_err, sram_mem_en, sram_rd_req, sram_wr_req, sram_address,
           out_data, out_valid
  );
endinterface

// File: rtl/sram_block_reader.sv
// Reads a block of consecutive SRAM rows (wrapping at DEPTH) and streams them out
// through a small FWFT FIFO; reads are only issued when a FIFO slot is guaranteed.
module sram_block_reader #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 100,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int LEN_W      = $clog2(DEPTH) + 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic                clk,
  input logic                rst,
  sram_block_reader_if.master bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_e;

  state_e            state_r;
  state_e            state_s;
  logic [ADDR_W-1:0] addr_r;
  logic [LEN_W-1:0]  issue_left_r;
  logic [LEN_W-1:0]  pop_left_r;
  logic              inflight_r;
  logic              busy_r;
  logic              done_r;
  logic              cmd_err_r;

  logic [DATA_W-1:0] fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W:0]    count_r;

  logic legal_s;
  logic accept_s;
  logic issue_s;
  logic push_s;
  logic pop_s;
  logic out_valid_s;

  assign legal_s     = (32'(bus.base_addr) < DEPTH) && (32'(bus.num_rows) <= DEPTH);
  assign accept_s    = (state_r == ST_IDLE) && bus.start && legal_s;
  assign out_valid_s = (count_r != '0);
  // The request still in flight holds a FIFO slot, so a returned row always fits.
  assign issue_s     = (state_r == ST_ISSUE) && (issue_left_r != '0) &&
                       ((32'(count_r) + 32'(inflight_r)) < FIFO_DEPTH);
  assign push_s      = bus.sram_rd_data_val && inflight_r;
  assign pop_s       = out_valid_s && bus.out_ready;

  // Next-state logic of the command sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          if (bus.num_rows == '0) state_s = ST_DONE;
          else                    state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (issue_s && (issue_left_r == LEN_W'(1))) state_s = ST_DRAIN;
        else                                        state_s = ST_ISSUE;
      end
      ST_DRAIN: begin
        if ((pop_left_r == '0) || (pop_s && (pop_left_r == LEN_W'(1)))) state_s = ST_DONE;
        else                                                            state_s = ST_DRAIN;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Sequencer state, address/count registers and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      addr_r       <= '0;
      issue_left_r <= '0;
      pop_left_r   <= '0;
      inflight_r   <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      cmd_err_r    <= 1'b0;
    end else begin
      state_r    <= state_s;
      inflight_r <= issue_s;
      busy_r     <= (state_s == ST_ISSUE) || (state_s == ST_DRAIN);
      done_r     <= (state_s == ST_DONE);
      cmd_err_r  <= (state_r == ST_IDLE) && bus.start && !legal_s;
      if (accept_s) begin
        addr_r       <= bus.base_addr;
        issue_left_r <= bus.num_rows;
        pop_left_r   <= bus.num_rows;
      end else begin
        if (issue_s) begin
          addr_r       <= (32'(addr_r) == (DEPTH - 1)) ? '0 : addr_r + ADDR_W'(1);
          issue_left_r <= issue_left_r - LEN_W'(1);
        end
        if (pop_s && (pop_left_r != '0)) begin
          pop_left_r <= pop_left_r - LEN_W'(1);
        end
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= bus.sram_rd_data;
    end
  end

  // FIFO pointers and occupancy; reset flushes any buffered rows.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
        2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign bus.busy         = busy_r;
  assign bus.done         = done_r;
  assign bus.cmd_err      = cmd_err_r;
  assign bus.sram_rd_req  = issue_s;
  assign bus.sram_mem_en  = issue_s;
  assign bus.sram_wr_req  = 1'b0;
  assign bus.sram_address = addr_r;
  assign bus.out_data     = fifo_mem_r[rd_ptr_r];
  assign bus.out_valid    = out_valid_s;

endmodule
